dispatch_queue: RTL and testbench



---
 rtl/dispatch_queue.sv | 138 +++++++++++++
 tb/tb_dispatch_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue.sv
// dispatch_queue: DEPTH-entry in-order instruction buffer between fetch and decode/dispatch.
// Latency: a word accepted at edge N appears at the registered head (out_reg_done=1) right after edge N.
// Backpressure: out_ready depends only on state (not full, not sealed, not in reset); in_stall freezes the head.
//
// Ports:
//   in_clk, in_rst_n                         clock, synchronous active-low reset
//   in_fetch_done/_insnbits/_branch_PC       upstream word, accepted when in_fetch_done & out_ready
//   out_ready                                queue can accept a word this cycle
//   in_stall                                 decode cannot take the head this cycle
//   in_flush                                 drop everything (redirect)
//   out_reg_done/_insnbits/_branch_PC        registered head entry
//   out_count/_full/_empty/_halted           occupancy and seal status
module dispatch_queue #(
  parameter int DEPTH       = 8,
  parameter int INSN_W      = 32,
  parameter int PC_W        = 64,
  parameter int SEAL_ON_HLT = 1,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_fetch_done,
  input  logic [INSN_W-1:0] in_fetch_insnbits,
  input  logic [PC_W-1:0]   in_fetch_branch_PC,
  output logic              out_ready,
  input  logic              in_stall,
  input  logic              in_flush,
  output logic              out_reg_done,
  output logic [INSN_W-1:0] out_reg_insnbits,
  output logic [PC_W-1:0]   out_reg_branch_PC,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_full,
  output logic              out_empty,
  output logic              out_halted
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [INSN_W-1:0] r_mem_insn [DEPTH];
  logic [PC_W-1:0]   r_mem_pc   [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_halted;
  logic              r_done;
  logic [INSN_W-1:0] r_insn;
  logic [PC_W-1:0]   r_pc;

  logic              w_full;
  logic              w_ready;
  logic              w_enq;
  logic              w_deq;
  logic              w_is_hlt;
  logic [PTR_W-1:0]  w_rd_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_remain;
  logic              w_bypass;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_ready  = ~w_full & ~r_halted & in_rst_n;
  assign w_enq    = in_fetch_done & w_ready;
  assign w_deq    = r_done & ~in_stall;
  assign w_is_hlt = ((in_fetch_insnbits & INSN_W'(32'hFFE0_001F)) == INSN_W'(32'hD440_0000));
  assign w_rd_nxt = r_rd_ptr + PTR_W'(w_deq);

  // Entries still stored after this cycle's dequeue; if none, a new word goes straight to the head.
  assign w_remain = r_count - CNT_W'(w_deq);
  assign w_bypass = (w_remain == '0);

  always_comb begin
    w_cnt_nxt = r_count;
    case ({w_enq, w_deq})
      2'b10:   w_cnt_nxt = r_count + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_count - CNT_W'(1);
      default: w_cnt_nxt = r_count;
    endcase
  end

  // Storage array carries no reset; only entries below r_count are ever read.
  always_ff @(posedge in_clk) begin
    if (w_enq && !in_flush) begin
      r_mem_insn[r_wr_ptr] <= in_fetch_insnbits;
      r_mem_pc[r_wr_ptr]   <= in_fetch_branch_PC;
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_halted <= 1'b0;
      r_done   <= 1'b0;
      r_insn   <= '0;
      r_pc     <= '0;
    end else if (in_flush) begin
      // Head data is left stale; only the valid flag matters.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_halted <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      if (w_enq && w_is_hlt && (SEAL_ON_HLT != 0)) begin
        r_halted <= 1'b1;
      end
      // Head reloads every cycle from the entry that is oldest after this edge;
      // while stalled that is the same entry, so the outputs hold.
      if (w_cnt_nxt == '0) begin
        r_done <= 1'b0;
      end else begin
        r_done <= 1'b1;
        if (w_bypass) begin
          r_insn <= in_fetch_insnbits;
          r_pc   <= in_fetch_branch_PC;
        end else begin
          r_insn <= r_mem_insn[w_rd_nxt];
          r_pc   <= r_mem_pc[w_rd_nxt];
        end
      end
    end
  end

  assign out_ready         = w_ready;
  assign out_reg_done      = r_done;
  assign out_reg_insnbits  = r_insn;
  assign out_reg_branch_PC = r_pc;
  assign out_count         = r_count;
  assign out_full          = w_full;
  assign out_empty         = (r_count == '0);
  assign out_halted        = r_halted;

endmodule

// File: tb/tb_dispatch_queue.sv
module tb_dispatch_queue;
  logic        in_clk = 1'b0;
  logic        in_rst_n = 1'b0;
  logic        in_fetch_done = 1'b0;
  logic [31:0] in_fetch_insnbits = '0;
  logic [63:0] in_fetch_branch_PC = '0;
  logic        out_ready;
  logic        in_stall = 1'b0;
  logic        in_flush = 1'b0;
  logic        out_reg_done;
  logic [31:0] out_reg_insnbits;
  logic [63:0] out_reg_branch_PC;
  logic [3:0]  out_count;
  logic        out_full;
  logic        out_empty;
  logic        out_halted;

  int total = 0;
  int bad = 0;

  dispatch_queue dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n),
    .in_fetch_done(in_fetch_done), .in_fetch_insnbits(in_fetch_insnbits),
    .in_fetch_branch_PC(in_fetch_branch_PC), .out_ready(out_ready),
    .in_stall(in_stall), .in_flush(in_flush),
    .out_reg_done(out_reg_done), .out_reg_insnbits(out_reg_insnbits),
    .out_reg_branch_PC(out_reg_branch_PC), .out_count(out_count),
    .out_full(out_full), .out_empty(out_empty), .out_halted(out_halted)
  );

  always #5 in_clk = ~in_clk;

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input logic [63:0] pc);
    in_fetch_done = 1'b1;
    in_fetch_insnbits = w;
    in_fetch_branch_PC = pc;
    step();
    in_fetch_done = 1'b0;
  endtask

  task automatic test_reset();
    in_rst_n = 1'b0;
    step();
    step();
    total++; if (out_reg_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", out_reg_done); end
    total++; if (out_reg_insnbits !== 32'h0) begin bad++; $display("FAIL reset_insn got=%h exp=0", out_reg_insnbits); end
    total++; if (out_reg_branch_PC !== 64'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", out_reg_branch_PC); end
    total++; if (out_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", out_count); end
    total++; if (out_empty !== 1'b1 || out_full !== 1'b0) begin bad++; $display("FAIL reset_flags empty=%0b full=%0b exp=1/0", out_empty, out_full); end
    total++; if (out_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", out_ready); end
    total++; if (out_halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b exp=0", out_halted); end
    in_rst_n = 1'b1;
    step();
    total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%0b exp=1", out_ready); end
  endtask

  task automatic test_latency();
    in_stall = 1'b0;
    push(32'h9100_0421, 64'h40);
    total++; if (out_reg_done !== 1'b1) begin bad++; $display("FAIL lat_done got=%0b exp=1", out_reg_done); end
    total++; if (out_reg_insnbits !== 32'h9100_0421) begin bad++; $display("FAIL lat_insn got=%h exp=91000421", out_reg_insnbits); end
    total++; if (out_reg_branch_PC !== 64'h40) begin bad++; $display("FAIL lat_pc got=%h exp=40", out_reg_branch_PC); end
    total++; if (out_count !== 4'd1) begin bad++; $display("FAIL lat_count got=%0d exp=1", out_count); end
    step();
    total++; if (out_reg_done !== 1'b0 || out_empty !== 1'b1) begin bad++; $display("FAIL lat_drain done=%0b empty=%0b exp=0/1", out_reg_done, out_empty); end
  endtask

  task automatic test_fill_full();
    in_stall = 1'b1;
    for (int i = 0; i < 8; i++) push(32'h100 + i, 64'h1000 + 64'(i));
    total++; if (out_full !== 1'b1 || out_ready !== 1'b0 || out_count !== 4'd8) begin bad++; $display("FAIL full_state full=%0b ready=%0b count=%0d exp=1/0/8", out_full, out_ready, out_count); end
    push(32'h108, 64'h1008);
    total++; if (out_count !== 4'd8) begin bad++; $display("FAIL full_ignore count=%0d exp=8", out_count); end
    total++; if (out_reg_insnbits !== 32'h100) begin bad++; $display("FAIL full_stall_head got=%h exp=100", out_reg_insnbits); end
    in_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (out_reg_done !== 1'b1 || out_reg_insnbits !== 32'h100 + i || out_reg_branch_PC !== 64'h1000 + 64'(i)) begin
        bad++; $display("FAIL full_drain[%0d] done=%0b insn=%h pc=%h exp insn=%h", i, out_reg_done, out_reg_insnbits, out_reg_branch_PC, 32'h100 + i);
      end
      step();
    end
    total++; if (out_empty !== 1'b1) begin bad++; $display("FAIL full_empty got=%0b exp=1", out_empty); end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    logic enq, deq;
    while (recv < 20 && cyc < 500) begin
      in_fetch_done = (sent < 20);
      in_fetch_insnbits = 32'h200 + sent;
      in_fetch_branch_PC = 64'(32'h200 + sent) << 2;
      in_stall = ($urandom_range(0, 9) < 3);
      #1;
      enq = in_fetch_done & out_ready;
      deq = out_reg_done & ~in_stall;
      if (deq) begin
        total++;
        if (out_reg_insnbits !== 32'h200 + recv || out_reg_branch_PC !== (64'(32'h200 + recv) << 2)) begin
          bad++; $display("FAIL wrap_order[%0d] insn=%h pc=%h exp insn=%h", recv, out_reg_insnbits, out_reg_branch_PC, 32'h200 + recv);
        end
        recv++;
      end
      if (enq) sent++;
      step();
      cyc++;
      total++; if (out_count > 4'd8) begin bad++; $display("FAIL wrap_count got=%0d exp<=8", out_count); end
    end
    in_fetch_done = 1'b0;
    in_stall = 1'b0;
    total++; if (recv != 20) begin bad++; $display("FAIL wrap_timeout recv=%0d exp=20", recv); end
    step();
    total++; if (out_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%0b exp=1", out_empty); end
  endtask

  task automatic test_simul();
    in_stall = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h300 + i, 64'h3000 + 64'(i));
    in_stall = 1'b0;
    push(32'h303, 64'h3003);
    total++; if (out_count !== 4'd3) begin bad++; $display("FAIL simul_count got=%0d exp=3", out_count); end
    total++; if (out_reg_insnbits !== 32'h301) begin bad++; $display("FAIL simul_head got=%h exp=301", out_reg_insnbits); end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (out_reg_done !== 1'b1 || out_reg_insnbits !== 32'h300 + i) begin
        bad++; $display("FAIL simul_drain[%0d] done=%0b insn=%h exp=%h", i, out_reg_done, out_reg_insnbits, 32'h300 + i);
      end
      step();
    end
    total++; if (out_empty !== 1'b1) begin bad++; $display("FAIL simul_empty got=%0b exp=1", out_empty); end
  endtask

  task automatic test_hlt();
    in_stall = 1'b1;
    push(32'hD440_0000, 64'h5000);
    total++; if (out_halted !== 1'b1 || out_ready !== 1'b0) begin bad++; $display("FAIL hlt_seal halted=%0b ready=%0b exp=1/0", out_halted, out_ready); end
    push(32'h1400_0001, 64'h5004);
    total++; if (out_count !== 4'd1) begin bad++; $display("FAIL hlt_block count=%0d exp=1", out_count); end
    total++; if (out_reg_done !== 1'b1 || out_reg_insnbits !== 32'hD440_0000) begin bad++; $display("FAIL hlt_head done=%0b insn=%h exp=1/d4400000", out_reg_done, out_reg_insnbits); end
    in_stall = 1'b0;
    step();
    total++; if (out_empty !== 1'b1 || out_halted !== 1'b1 || out_ready !== 1'b0) begin bad++; $display("FAIL hlt_after empty=%0b halted=%0b ready=%0b exp=1/1/0", out_empty, out_halted, out_ready); end
    in_flush = 1'b1;
    step();
    in_flush = 1'b0;
    total++; if (out_halted !== 1'b0 || out_ready !== 1'b1 || out_empty !== 1'b1) begin bad++; $display("FAIL hlt_flush halted=%0b ready=%0b empty=%0b exp=0/1/1", out_halted, out_ready, out_empty); end
  endtask

  task automatic test_flush_reset();
    in_stall = 1'b1;
    for (int i = 0; i < 5; i++) push(32'h400 + i, 64'h4000 + 64'(i));
    total++; if (out_count !== 4'd5) begin bad++; $display("FAIL flush_pre count=%0d exp=5", out_count); end
    in_flush = 1'b1;
    in_stall = 1'b0;
    push(32'h4FF, 64'h40FF);
    in_flush = 1'b0;
    total++; if (out_count !== 4'd0 || out_reg_done !== 1'b0 || out_empty !== 1'b1) begin bad++; $display("FAIL flush_clear count=%0d done=%0b empty=%0b exp=0/0/1", out_count, out_reg_done, out_empty); end
    push(32'h500, 64'h5500);
    total++; if (out_reg_done !== 1'b1 || out_reg_insnbits !== 32'h500 || out_count !== 4'd1) begin bad++; $display("FAIL flush_restart done=%0b insn=%h count=%0d exp=1/500/1", out_reg_done, out_reg_insnbits, out_count); end
    step();
    in_stall = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h600 + i, 64'h6000 + 64'(i));
    in_rst_n = 1'b0;
    in_flush = 1'b1;
    push(32'h6FF, 64'h60FF);
    in_flush = 1'b0;
    total++;
    if (out_reg_done !== 1'b0 || out_reg_insnbits !== 32'h0 || out_reg_branch_PC !== 64'h0 || out_count !== 4'd0 ||
        out_halted !== 1'b0 || out_empty !== 1'b1 || out_full !== 1'b0 || out_ready !== 1'b0) begin
      bad++; $display("FAIL midreset done=%0b insn=%h pc=%h count=%0d halted=%0b empty=%0b full=%0b ready=%0b exp all zero except empty=1",
                      out_reg_done, out_reg_insnbits, out_reg_branch_PC, out_count, out_halted, out_empty, out_full, out_ready);
    end
    in_rst_n = 1'b1;
    in_stall = 1'b0;
    step();
    total++; if (out_empty !== 1'b1 || out_ready !== 1'b1) begin bad++; $display("FAIL midreset_release empty=%0b ready=%0b exp=1/1", out_empty, out_ready); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_full();
    test_wrap();
    test_simul();
    test_hlt();
    test_flush_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
